// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external full-adder cell LSB-first, one bit per clock,
// and collects sum bits into a shift register. Holds the last completed result.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;

  // A new operation is taken from IDLE or straight out of DONE; start is ignored in RUN.
  assign accept = start && (state != RUN);

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign fa_a   = busy & a_sr[0];
  assign fa_b   = busy & b_sr[0];
  assign fa_cin = busy & carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= {fa_sum, sum_sr[WIDTH-1:1]};
            cout  <= fa_cout;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a gate-level full adder on fa_*, a driver that pushes
// a + b + cin into a queue, and a monitor that checks each done pulse and the held result.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];
  logic [W:0] held = '0;
  logic [W:0] mon_e;
  logic       mon_en = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Monitor: every done consumes one expectation; otherwise the result must hold still.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("result", {23'd0, cout, sum}, {23'd0, mon_e});
          held = mon_e;
        end
      end else begin
        chk("hold", {23'd0, cout, sum}, {23'd0, held});
      end
      chk("busy_done_excl", {31'd0, busy & done}, 0);
      if (!busy) chk("fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 0);
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("issue_timeout", 1, 0);
    a = ia; b = ib; cin = ic; start = 1'b1;
    exp_q.push_back(ref_add(ia, ib, ic));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 300);
    if (n >= 300) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int lat, bc;
    #12;
    chk("reset_state", {25'd0, busy, done, cout, fa_a, fa_b, fa_cin, 1'b0}, 0);
    chk("reset_sum", {24'd0, sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Case 1 with latency measurement from the start edge
    issue(8'h5A, 8'h3C, 1'b0);
    lat = 0; bc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) break;
    end
    chk("latency", lat, 9);
    chk("busy_cycles", bc, 8);
    chk("case1", {23'd0, cout, sum}, 32'h096);
    wait_drain();

    issue(8'hFF, 8'h01, 1'b0);  wait_drain();
    chk("case2", {23'd0, cout, sum}, 32'h100);
    issue(8'hFF, 8'hFF, 1'b1);  wait_drain();
    chk("case3a", {23'd0, cout, sum}, 32'h1FF);
    issue(8'h00, 8'h00, 1'b0);  wait_drain();
    chk("case3b", {23'd0, cout, sum}, 32'h000);

    // Case 4: start pulse mid-RUN must be ignored
    issue(8'h5A, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain();
    chk("case4", {23'd0, cout, sum}, 32'h096);
    repeat (12) @(negedge clk);
    chk("case4_idle", {31'd0, busy}, 0);

    // Case 5: start held through RUN and DONE launches the next op without a bubble
    issue(8'h5A, 8'h3C, 1'b0);
    a = 8'h10; b = 8'h20; cin = 1'b1; start = 1'b1;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("case5_done_seen", {31'd0, done}, 1);
    chk("case5_first", {23'd0, cout, sum}, 32'h096);
    exp_q.push_back(ref_add(8'h10, 8'h20, 1'b1));
    @(posedge clk);
    #1 start = 1'b0;
    chk("no_bubble", {31'd0, busy}, 1);
    wait_drain();
    chk("case5_second", {23'd0, cout, sum}, 32'h031);

    // Case 6: reset in the fourth RUN cycle aborts everything
    issue(8'h5A, 8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_abort", {25'd0, busy, done, cout, fa_a, fa_b, fa_cin, 1'b0}, 0);
    chk("reset_abort_sum", {24'd0, sum}, 0);
    exp_q.delete();
    held = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_done", {31'd0, done}, 0);
    end
    rst_n = 1'b1;
    issue(8'h80, 8'h80, 1'b1);  wait_drain();
    chk("case6_after", {23'd0, cout, sum}, 32'h101);

    // Randomized traffic, gap 0 exercises back-to-back issue out of DONE
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    wait_drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
